led_cmd_engine: RTL and testbench

//  Parametrised LED command engine: NLED-bit LED state register driven by opcode commands over a valid/ready port.

---
 rtl/led_cmd_engine.sv | 99 +++++++++
 tb/tb_led_cmd_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/led_cmd_engine.sv
// led_cmd_engine: NLED-bit LED state register driven by valid/ready opcodes, with per-LED blink and read-back.
// Optional global PWM dimming is built when LEDMNGT_PWM_EN is defined.
module led_cmd_engine #(
   parameter int NLED  = 8,
   parameter int DIV_W = 16,
   parameter int PWM_W = 4
) (
   input  logic            MCLK,
   input  logic            nRST,
   input  logic            CMD_VALID,
   output logic            CMD_READY,
   input  logic [3:0]      CMD_OP,
   input  logic [NLED-1:0] CMD_DATA,
   output logic            RD_VALID,
   input  logic            RD_READY,
   output logic [NLED-1:0] RD_DATA,
   output logic [NLED-1:0] LED
);
   logic [NLED-1:0]  r_state, r_mask, r_rd_data, r_led;
   logic [NLED-1:0]  w_state_nxt, w_mask_nxt, w_rd_data_nxt, w_eff, w_led_nxt;
   logic [DIV_W-1:0] r_rate, r_pre, w_rate_nxt, w_pre_nxt, w_rate_d;
   logic             r_phase, r_rd_valid, w_phase_nxt, w_rd_valid_nxt;
   logic             w_acc, w_rd_cmd, w_rate_set;

   assign CMD_READY = ~r_rd_valid;
   assign RD_VALID  = r_rd_valid;
   assign RD_DATA   = r_rd_data;
   assign LED       = r_led;

   assign w_acc      = CMD_VALID & CMD_READY;
   assign w_rd_cmd   = w_acc && CMD_OP == 4'h7;
   assign w_rate_set = w_acc && CMD_OP == 4'h9;
   assign w_rate_d   = DIV_W'(CMD_DATA);

   always_comb begin
      w_state_nxt = r_state;
      if (w_acc)
         case (CMD_OP)
            4'h0:    w_state_nxt = '0;
            4'h1:    w_state_nxt = r_state | CMD_DATA;
            4'h2:    w_state_nxt = r_state & ~CMD_DATA;
            4'h3:    w_state_nxt = r_state ^ CMD_DATA;
            4'h4:    w_state_nxt = r_state ~^ CMD_DATA;
            4'h5:    w_state_nxt = ~r_state;
            4'h6:    w_state_nxt = CMD_DATA;
            default: w_state_nxt = r_state;
         endcase
   end

   // Prescaler spends rate+1 cycles in each phase; a RATE write restarts it in the lit phase.
   always_comb begin
      w_mask_nxt     = (w_acc && CMD_OP == 4'h8) ? CMD_DATA : r_mask;
      w_rate_nxt     = w_rate_set ? w_rate_d : r_rate;
      w_pre_nxt      = w_rate_set ? w_rate_d : (r_rate == '0) ? '0 :
                       (r_pre == '0) ? r_rate : r_pre - DIV_W'(1);
      w_phase_nxt    = w_rate_set || r_rate == '0 || ((r_pre == '0) ? ~r_phase : r_phase);
      w_rd_valid_nxt = w_rd_cmd | (r_rd_valid & ~RD_READY);
      w_rd_data_nxt  = w_rd_cmd ? r_state : r_rd_data;
      w_eff          = r_state & ~(r_mask & {NLED{~r_phase}});
   end

`ifdef LEDMNGT_PWM_EN
   logic [PWM_W-1:0] r_duty, r_pwm_cnt;

   always_ff @(posedge MCLK or negedge nRST)
      if (!nRST) begin
         r_duty    <= '1;
         r_pwm_cnt <= '0;
      end else begin
         r_duty    <= (w_acc && CMD_OP == 4'hA) ? PWM_W'(CMD_DATA) : r_duty;
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end

   assign w_led_nxt = w_eff & {NLED{r_pwm_cnt < r_duty}};
`else
   assign w_led_nxt = w_eff;
`endif

   always_ff @(posedge MCLK or negedge nRST)
      if (!nRST) begin
         r_state    <= '0;
         r_mask     <= '0;
         r_rate     <= '0;
         r_pre      <= '0;
         r_phase    <= 1'b1;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_led      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_mask     <= w_mask_nxt;
         r_rate     <= w_rate_nxt;
         r_pre      <= w_pre_nxt;
         r_phase    <= w_phase_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_rd_data  <= w_rd_data_nxt;
         r_led      <= w_led_nxt;
      end
endmodule

// File: tb/tb_led_cmd_engine.sv
// tb_led_cmd_engine: directed tests of led_cmd_engine opcodes, read-back handshake, blink and async reset.
// Define LEDMNGT_PWM_EN for both bench and RTL to exercise the dimming path instead of the DUTY-as-NOP check.
module tb_led_cmd_engine;
   logic       MCLK = 1'b0;
   logic       nRST = 1'b0;
   logic       CMD_VALID = 1'b0;
   logic       RD_READY = 1'b0;
   logic [3:0] CMD_OP = 4'h0;
   logic [7:0] CMD_DATA = 8'h00;
   logic       CMD_READY, RD_VALID;
   logic [7:0] RD_DATA, LED;
   int         checks = 0;
   int         failures = 0;

   led_cmd_engine #(.NLED(8), .DIV_W(16), .PWM_W(4)) dut (
      .MCLK(MCLK), .nRST(nRST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
      .RD_DATA(RD_DATA), .LED(LED)
   );

   always #5 MCLK = ~MCLK;

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic cmd(input logic [3:0] op, input logic [7:0] d);
      int n = 0;
      CMD_OP = op; CMD_DATA = d; CMD_VALID = 1'b1;
      while (!CMD_READY && n < 50) begin @(negedge MCLK); n++; end
      checks++;
      if (!CMD_READY) begin
         failures++;
         $display("FAIL cmd_accept op=%0h CMD_READY=%b want 1 within 50 cycles", op, CMD_READY);
      end else @(posedge MCLK);
      @(negedge MCLK);
      CMD_VALID = 1'b0;
   endtask

   task automatic do_read(output logic [7:0] d, output logic v, output logic r);
      cmd(4'h7, 8'h00);
      v = RD_VALID; r = CMD_READY; d = RD_DATA;
      RD_READY = 1'b1;
      @(negedge MCLK);
      RD_READY = 1'b0;
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      repeat (2) @(negedge MCLK);
      checks++; if (LED !== 8'h00) begin failures++; $display("FAIL reset_led got %h want 00", LED); end
      checks++; if (RD_VALID !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got %b want 0", RD_VALID); end
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL reset_rd_data got %h want 00", RD_DATA); end
      checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got %b want 1", CMD_READY); end
      nRST = 1'b1;
      @(negedge MCLK);
      checks++; if (LED !== 8'h00) begin failures++; $display("FAIL post_reset_led got %h want 00", LED); end
   endtask

   task automatic test_set_tgl;
      cmd(4'h1, 8'h0F);
      checks++; if (LED !== 8'h00) begin failures++; $display("FAIL set_lag got %h want 00", LED); end
      @(negedge MCLK);
      checks++; if (LED !== 8'h0F) begin failures++; $display("FAIL set_led got %h want 0f", LED); end
      cmd(4'h3, 8'h3C);
      checks++; if (LED !== 8'h0F) begin failures++; $display("FAIL tgl_lag got %h want 0f", LED); end
      @(negedge MCLK);
      checks++; if (LED !== 8'h33) begin failures++; $display("FAIL tgl_led got %h want 33", LED); end
   endtask

   task automatic test_ops;
      logic [3:0] ops [5] = '{4'h6, 4'h5, 4'h4, 4'h2, 4'h0};
      logic [7:0] dat [5] = '{8'hA5, 8'h00, 8'hFF, 8'h81, 8'h00};
      logic [7:0] exp [5] = '{8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h00};
      logic [7:0] d;
      logic       v, r;
      for (int i = 0; i < 5; i++) begin
         cmd(ops[i], dat[i]);
         do_read(d, v, r);
         checks++; if (v !== 1'b1 || r !== 1'b0) begin failures++; $display("FAIL op%0d_rd_flags got valid=%b ready=%b want 1 0", i, v, r); end
         checks++; if (d !== exp[i]) begin failures++; $display("FAIL op%0d_state got %h want %h", i, d, exp[i]); end
      end
   endtask

   task automatic test_read_hold;
      cmd(4'h6, 8'h55);
      cmd(4'h7, 8'h00);
      CMD_OP = 4'h1; CMD_DATA = 8'hFF; CMD_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (RD_VALID !== 1'b1 || RD_DATA !== 8'h55 || CMD_READY !== 1'b0) begin
            failures++;
            $display("FAIL read_hold%0d got valid=%b data=%h ready=%b want 1 55 0", i, RD_VALID, RD_DATA, CMD_READY);
         end
         @(negedge MCLK);
      end
      RD_READY = 1'b1;
      @(negedge MCLK);
      RD_READY = 1'b0;
      checks++; if (RD_VALID !== 1'b0 || CMD_READY !== 1'b1) begin failures++; $display("FAIL read_release got valid=%b ready=%b want 0 1", RD_VALID, CMD_READY); end
      @(negedge MCLK);
      CMD_VALID = 1'b0;
      checks++; if (LED !== 8'h55) begin failures++; $display("FAIL held_cmd_early got %h want 55", LED); end
      @(negedge MCLK);
      checks++; if (LED !== 8'hFF) begin failures++; $display("FAIL held_cmd_taken got %h want ff", LED); end
   endtask

   task automatic test_blink;
      logic [7:0] e;
      cmd(4'h6, 8'hFF);
      cmd(4'h8, 8'h0F);
      cmd(4'h9, 8'h03);
      for (int k = 1; k <= 16; k++) begin
         @(negedge MCLK);
         e = (((k - 1) / 4) % 2 == 0) ? 8'hFF : 8'hF0;
         checks++; if (LED !== e) begin failures++; $display("FAIL blink_c%0d got %h want %h", k, LED, e); end
      end
      cmd(4'h9, 8'h00);
      for (int k = 0; k < 4; k++) begin
         @(negedge MCLK);
         checks++; if (LED !== 8'hFF) begin failures++; $display("FAIL rate0_c%0d got %h want ff", k, LED); end
      end
   endtask

   task automatic test_async_reset;
      logic [7:0] d;
      logic       v, r;
      cmd(4'h9, 8'h03);
      repeat (6) @(negedge MCLK);
      cmd(4'h7, 8'h00);
      #2 nRST = 1'b0;
      #1;
      checks++;
      if (LED !== 8'h00 || RD_VALID !== 1'b0 || CMD_READY !== 1'b1 || RD_DATA !== 8'h00) begin
         failures++;
         $display("FAIL async_reset got led=%h valid=%b ready=%b data=%h want 00 0 1 00", LED, RD_VALID, CMD_READY, RD_DATA);
      end
      @(negedge MCLK);
      nRST = 1'b1;
      @(negedge MCLK);
      do_read(d, v, r);
      checks++; if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL post_areset_state got %h valid=%b want 00 1", d, v); end
      cmd(4'h6, 8'hFF);
      repeat (8) begin
         @(negedge MCLK);
         checks++; if (LED !== 8'hFF) begin failures++; $display("FAIL post_areset_noblink got %h want ff", LED); end
      end
   endtask

`ifdef LEDMNGT_PWM_EN
   task automatic test_pwm;
      int hi = 0;
      cmd(4'h6, 8'h01);
      cmd(4'hA, 8'h04);
      @(negedge MCLK);
      for (int k = 0; k < 32; k++) begin
         @(negedge MCLK);
         if (LED[0] === 1'b1) hi++;
         checks++; if (LED[7:1] !== 7'h00) begin failures++; $display("FAIL pwm_upper got %h want 00", LED[7:1]); end
      end
      checks++; if (hi !== 8) begin failures++; $display("FAIL pwm_duty4 got %0d lit cycles want 8 of 32", hi); end
      cmd(4'hA, 8'h00);
      for (int k = 0; k < 17; k++) begin
         @(negedge MCLK);
         checks++; if (LED !== 8'h00) begin failures++; $display("FAIL pwm_duty0_c%0d got %h want 00", k, LED); end
      end
   endtask
`else
   task automatic test_nop;
      logic [7:0] d;
      logic       v, r;
      cmd(4'h6, 8'h3C);
      cmd(4'hA, 8'hFF);
      cmd(4'hF, 8'hFF);
      do_read(d, v, r);
      checks++; if (d !== 8'h3C) begin failures++; $display("FAIL nop_state got %h want 3c", d); end
      checks++; if (LED !== 8'h3C) begin failures++; $display("FAIL nop_led got %h want 3c", LED); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge MCLK);
      test_reset();
      test_set_tgl();
      test_ops();
      test_read_hold();
      test_blink();
      test_async_reset();
`ifdef LEDMNGT_PWM_EN
      test_pwm();
`else
      test_nop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
